// File: rtl/dbus_pkg.sv
// Shared encodings and FSM state type for the data-bus initiator.
package dbus_pkg;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  localparam logic [1:0] W_RSVD = 2'b11;

  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/dbus_if.sv
// CPU request/response channel plus the d_* data-port bus, seen from master and slave sides.
interface dbus_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_width;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        d_access;
  logic        d_cs;
  logic [31:0] d_addr;
  logic [3:0]  d_bytesel;
  logic [31:0] d_wr_val;
  logic        d_wr_en;
  logic [31:0] d_data;
  logic        d_ack;

  modport master (
    input  req_valid, req_wr, req_width, req_signed, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output d_access, d_cs, d_addr, d_bytesel, d_wr_val, d_wr_en,
    input  d_data, d_ack
  );

  modport slave (
    output req_valid, req_wr, req_width, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  d_access, d_cs, d_addr, d_bytesel, d_wr_val, d_wr_en,
    output d_data, d_ack
  );

endinterface

// File: rtl/dbus_lane_align.sv
// Byte-lane steering: request-side bytesel/store replication/misalignment check,
// response-side lane extraction with sign or zero extension.
module dbus_lane_align
  import dbus_pkg::*;
(
  input  logic [1:0]  i_st_width,
  input  logic [1:0]  i_st_addr,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_bytesel,
  output logic [31:0] o_wr_val,
  output logic        o_misalign,
  input  logic [1:0]  i_ld_width,
  input  logic [1:0]  i_ld_addr,
  input  logic        i_ld_signed,
  input  logic [31:0] i_ld_data,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_bytesel  = 4'b0000;
    o_wr_val   = 32'h0;
    o_misalign = 1'b0;
    case (i_st_width)
      W_BYTE: begin
        o_bytesel = 4'b0001 << i_st_addr;
        o_wr_val  = {4{i_st_wdata[7:0]}};
      end
      W_HALF: begin
        o_bytesel  = i_st_addr[1] ? 4'b1100 : 4'b0011;
        o_wr_val   = {2{i_st_wdata[15:0]}};
        o_misalign = i_st_addr[0];
      end
      W_WORD: begin
        o_bytesel  = 4'b1111;
        o_wr_val   = i_st_wdata;
        o_misalign = |i_st_addr;
      end
      default: o_misalign = 1'b1;
    endcase
  end

  // Unselected lanes of the slave data are never passed through.
  always_comb begin
    case (i_ld_addr)
      2'd0:    w_byte = i_ld_data[7:0];
      2'd1:    w_byte = i_ld_data[15:8];
      2'd2:    w_byte = i_ld_data[23:16];
      default: w_byte = i_ld_data[31:24];
    endcase
    w_half = i_ld_addr[1] ? i_ld_data[31:16] : i_ld_data[15:0];
    case (i_ld_width)
      W_BYTE:  o_ld_data = {{24{i_ld_signed & w_byte[7]}}, w_byte};
      W_HALF:  o_ld_data = {{16{i_ld_signed & w_half[15]}}, w_half};
      W_WORD:  o_ld_data = i_ld_data;
      default: o_ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dbus_master.sv
// Single-outstanding load/store initiator on the d_* bus with ack timeout
// so a dead slave turns into an error response instead of a hung pipeline.
module dbus_master
  import dbus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  dbus_if.master bus
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      r_state;
  state_t      w_next;
  logic        r_wr;
  logic        r_signed;
  logic [1:0]  r_width;
  logic [31:0] r_addr;
  logic [3:0]  r_bytesel;
  logic [31:0] r_wr_val;
  logic [7:0]  r_cnt;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic        w_accept;
  logic        w_done_ok;
  logic        w_done_err;
  logic [3:0]  w_bytesel;
  logic [31:0] w_wr_val;
  logic        w_misalign;
  logic [31:0] w_ld_data;

  dbus_lane_align u_align (
    .i_st_width  (bus.req_width),
    .i_st_addr   (bus.req_addr[1:0]),
    .i_st_wdata  (bus.req_wdata),
    .o_bytesel   (w_bytesel),
    .o_wr_val    (w_wr_val),
    .o_misalign  (w_misalign),
    .i_ld_width  (r_width),
    .i_ld_addr   (r_addr[1:0]),
    .i_ld_signed (r_signed),
    .i_ld_data   (bus.d_data),
    .o_ld_data   (w_ld_data)
  );

  assign w_accept = bus.req_valid && (r_state == S_IDLE);

  always_comb begin
    w_next     = r_state;
    w_done_ok  = 1'b0;
    w_done_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misalign) begin
            w_next     = S_RESP;
            w_done_err = 1'b1;
          end else begin
            w_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (bus.d_ack) begin
          w_next    = S_RESP;
          w_done_ok = 1'b1;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // An ack on the final counted cycle still wins over the timeout.
        if (bus.d_ack) begin
          w_next    = S_RESP;
          w_done_ok = 1'b1;
        end else if (r_cnt == TO_LIMIT) begin
          w_next     = S_RESP;
          w_done_err = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr        <= 1'b0;
      r_signed    <= 1'b0;
      r_width     <= W_BYTE;
      r_addr      <= 32'h0;
      r_bytesel   <= 4'b0000;
      r_wr_val    <= 32'h0;
      r_cnt       <= 8'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_wr      <= bus.req_wr;
        r_signed  <= bus.req_signed;
        r_width   <= bus.req_width;
        r_addr    <= bus.req_addr;
        r_bytesel <= w_bytesel;
        r_wr_val  <= w_wr_val;
      end
      if (r_state == S_ISSUE)
        r_cnt <= 8'd1;
      else if (r_state == S_WAIT)
        r_cnt <= r_cnt + 8'd1;
      else
        r_cnt <= 8'd0;
      r_rsp_valid <= w_done_ok | w_done_err;
      r_rsp_err   <= w_done_err;
      r_rsp_rdata <= (w_done_ok && !r_wr) ? w_ld_data : 32'h0;
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.d_access  = (r_state == S_ISSUE);
  assign bus.d_cs      = (r_state == S_ISSUE);
  assign bus.d_wr_en   = (r_state == S_ISSUE) && r_wr;
  assign bus.d_addr    = {r_addr[31:2], 2'b00};
  assign bus.d_bytesel = r_bytesel;
  assign bus.d_wr_val  = r_wr_val;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dbus_master.sv
// Scoreboard bench for dbus_master: RAM slave with 1-cycle ack or dead slave,
// bus-side and response-side expectations queued at request time.
module tb_dbus_master;
  import dbus_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } rsp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  bs;
    logic [31:0] wv;
    logic        wr;
  } bus_exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   cyc;
  int   acc_cyc;
  int   rsp_seen;
  int   ack_mode;
  logic ack_pending;
  logic inject_ack;
  logic [31:0] pend_addr;
  logic [31:0] mem [logic [31:0]];
  rsp_exp_t rsp_q[$];
  bus_exp_t bus_q[$];
  rsp_exp_t mon_re;

  dbus_if bus ();

  dbus_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.req_valid && bus.req_ready) acc_cyc <= cyc;
  end

  // Slave: checks every strobe against the queued expectation, applies stores.
  initial begin
    bus.d_ack  = 1'b0;
    bus.d_data = 32'h0;
    forever begin
      @(negedge clk);
      bus.d_ack = 1'b0;
      if (ack_pending || inject_ack) begin
        bus.d_ack   = 1'b1;
        bus.d_data  = rd_word(pend_addr);
        ack_pending = 1'b0;
        inject_ack  = 1'b0;
      end
      if (bus.d_access === 1'b1) begin
        check("d_cs", 32'(bus.d_cs), 32'd1);
        if (bus_q.size() == 0) begin
          check("unexp_access", 32'd1, 32'd0);
        end else begin
          bus_exp_t be;
          be = bus_q.pop_front();
          check("d_addr", bus.d_addr, be.addr);
          check("d_bytesel", 32'(bus.d_bytesel), 32'(be.bs));
          check("d_wr_en", 32'(bus.d_wr_en), 32'(be.wr));
          if (be.wr) check("d_wr_val", bus.d_wr_val, be.wv);
        end
        if (bus.d_wr_en === 1'b1) begin
          logic [31:0] w;
          w = rd_word(bus.d_addr);
          for (int i = 0; i < 4; i++)
            if (bus.d_bytesel[i]) w[8*i +: 8] = bus.d_wr_val[8*i +: 8];
          mem[bus.d_addr] = w;
        end
        if (ack_mode == 0) begin
          ack_pending = 1'b1;
          pend_addr   = bus.d_addr;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        check("unexp_rsp", 32'd1, 32'd0);
      end else begin
        mon_re = rsp_q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, mon_re.rdata);
        check("rsp_err", 32'(bus.rsp_err), 32'(mon_re.err));
        check("rsp_lat", 32'(cyc - acc_cyc), 32'(mon_re.lat));
      end
      rsp_seen <= rsp_seen + 1;
    end
  end

  task automatic issue(input logic wr, input logic [1:0] w, input logic sgn,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit exp_bus, input logic [3:0] bs, input logic [31:0] wv,
                       input bit exp_rsp, input logic [31:0] rdata, input logic err,
                       input int lat);
    int n = 0;
    bus_exp_t be;
    rsp_exp_t re;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ready !== 1'b1) check("req_ready_wait", 32'(bus.req_ready), 32'd1);
    if (exp_bus) begin
      be.addr = {a[31:2], 2'b00};
      be.bs   = bs;
      be.wv   = wv;
      be.wr   = wr;
      bus_q.push_back(be);
    end
    if (exp_rsp) begin
      re.rdata = rdata;
      re.err   = err;
      re.lat   = lat;
      rsp_q.push_back(re);
    end
    bus.req_wr     = wr;
    bus.req_width  = w;
    bus.req_signed = sgn;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int start = rsp_seen;
    int n = 0;
    while (rsp_seen == start && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (rsp_seen == start) begin
      check("rsp_wait", 32'd0, 32'd1);
      if (rsp_q.size() != 0) void'(rsp_q.pop_front());
    end
  endtask

  task automatic txn(input logic wr, input logic [1:0] w, input logic sgn,
                     input logic [31:0] a, input logic [31:0] wd,
                     input bit exp_bus, input logic [3:0] bs, input logic [31:0] wv,
                     input logic [31:0] rdata, input logic err, input int lat);
    issue(wr, w, sgn, a, wd, exp_bus, bs, wv, 1'b1, rdata, err, lat);
    wait_rsp();
  endtask

  task automatic check_reset_outs();
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_d_access", 32'(bus.d_access), 32'd0);
    check("rst_d_cs", 32'(bus.d_cs), 32'd0);
    check("rst_d_wr_en", 32'(bus.d_wr_en), 32'd0);
    check("rst_d_addr", bus.d_addr, 32'h0);
    check("rst_d_bytesel", 32'(bus.d_bytesel), 32'h0);
    check("rst_d_wr_val", bus.d_wr_val, 32'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    cyc = 0;
    acc_cyc = 0;
    rsp_seen = 0;
    ack_mode = 0;
    ack_pending = 1'b0;
    inject_ack = 1'b0;
    pend_addr = 32'h0;
    bus.req_valid = 1'b0;
    bus.req_wr = 1'b0;
    bus.req_width = W_BYTE;
    bus.req_signed = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outs();
    @(negedge clk) rst_n = 1'b1;

    // Aligned traffic behind a 1-cycle-ack RAM.
    txn(1, W_WORD, 0, 32'h100, 32'hdeadbeef, 1, 4'hf, 32'hdeadbeef, 32'h0, 0, 3);
    txn(0, W_WORD, 0, 32'h100, 32'h0, 1, 4'hf, 32'h0, 32'hdeadbeef, 0, 3);
    txn(0, W_BYTE, 0, 32'h101, 32'h0, 1, 4'b0010, 32'h0, 32'h000000be, 0, 3);
    txn(0, W_HALF, 1, 32'h102, 32'h0, 1, 4'b1100, 32'h0, 32'hffffdead, 0, 3);
    txn(1, W_WORD, 0, 32'h100, 32'h80000000, 1, 4'hf, 32'h80000000, 32'h0, 0, 3);
    txn(0, W_BYTE, 1, 32'h103, 32'h0, 1, 4'b1000, 32'h0, 32'hffffff80, 0, 3);
    txn(0, W_BYTE, 0, 32'h103, 32'h0, 1, 4'b1000, 32'h0, 32'h00000080, 0, 3);
    txn(1, W_HALF, 0, 32'h202, 32'habcd1234, 1, 4'b1100, 32'h12341234, 32'h0, 0, 3);
    txn(0, W_HALF, 0, 32'h202, 32'h0, 1, 4'b1100, 32'h0, 32'h00001234, 0, 3);
    txn(1, W_BYTE, 0, 32'h201, 32'h000000a5, 1, 4'b0010, 32'ha5a5a5a5, 32'h0, 0, 3);
    txn(0, W_WORD, 0, 32'h200, 32'h0, 1, 4'hf, 32'h0, 32'h1234a500, 0, 3);

    // Misaligned and reserved widths: error next cycle, no bus strobe.
    txn(0, W_HALF, 0, 32'h101, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 1);
    txn(0, W_RSVD, 0, 32'h100, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 1);
    txn(1, W_WORD, 0, 32'h102, 32'h55aa55aa, 0, 4'h0, 32'h0, 32'h0, 1, 1);

    // Dead slave: timeout after 8 wait cycles, late ack ignored.
    ack_mode = 1;
    txn(0, W_WORD, 0, 32'h100, 32'h0, 1, 4'hf, 32'h0, 32'h0, 1, 10);
    @(posedge clk);
    @(negedge clk);
    #1 pend_addr = 32'h100;
    inject_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("late_ack_rsp", 32'(bus.rsp_valid), 32'd0);
      check("late_ack_ready", 32'(bus.req_ready), 32'd1);
    end
    ack_mode = 0;
    txn(0, W_WORD, 0, 32'h100, 32'h0, 1, 4'hf, 32'h0, 32'h80000000, 0, 3);

    // Reset while waiting on a dead slave.
    ack_mode = 1;
    issue(0, W_WORD, 0, 32'h200, 32'h0, 1, 4'hf, 32'h0, 0, 32'h0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 check_reset_outs();
    @(negedge clk) rst_n = 1'b1;
    #1 pend_addr = 32'h200;
    inject_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1 check("post_rst_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    ack_mode = 0;
    txn(0, W_BYTE, 0, 32'h103, 32'h0, 1, 4'b1000, 32'h0, 32'h00000080, 0, 3);

    repeat (2) @(negedge clk);
    check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    check("bus_q_empty", 32'(bus_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
